// File: rtl/conv_mxi8tobf16.sv
// conv_mxi8tobf16 : streaming MXINT8 -> BF16 block decoder.
//
// Accepts one MX block per handshake (k signed integer elements plus one
// shared E8M0 exponent). It holds the block in a buffer and replays it as
// k/lanes BF16 beats on a valid/ready stream.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid/o_ready  input block handshake
//   i_mx_vec         k elements of bit_width bits, element 0 in the LSBs
//   i_mx_exp         shared E8M0 exponent (bias 127, 0xFF = NaN)
//   o_valid/i_ready  output beat handshake
//   o_bf16_vec       lanes BF16 values; lane j = element o_beat*lanes+j
//   o_beat           beat index within the block
//   o_last           final beat of the block
//
// state | meaning
// IDLE  | buffer empty, waiting for a block (o_ready=1)
// SEND  | buffer holds a block, streaming beat o_beat (o_valid=1)
module conv_mxi8tobf16 #(
  parameter  int bit_width = 8,
  parameter  int k         = 32,
  parameter  int lanes     = 8,
  localparam int NB        = k / lanes,
  localparam int BW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [k-1:0][bit_width-1:0]     i_mx_vec,
  input  logic [7:0]                      i_mx_exp,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [lanes-1:0][15:0]          o_bf16_vec,
  output logic [BW-1:0]                   o_beat,
  output logic                            o_last
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  state_t                                   state_q;
  logic [BW-1:0]                            beat_q;
  // Grouped by beat so the current beat is a single index into the buffer.
  logic [NB-1:0][lanes-1:0][bit_width-1:0]  vec_q;
  logic [7:0]                               exp_q;

  // Handshake outputs are decoded straight from the state and beat
  // registers, so reset clears o_valid without waiting for a clock edge.
  assign o_valid = (state_q == SEND);
  assign o_beat  = beat_q;
  assign o_last  = o_valid && (beat_q == LAST_BEAT);
  assign o_ready = !o_valid || (o_last && i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      vec_q   <= '0;
      exp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            vec_q   <= i_mx_vec;
            exp_q   <= i_mx_exp;
            beat_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (beat_q == LAST_BEAT) begin
              beat_q <= '0;
              // The next block is taken in the same cycle the last beat
              // leaves, so back-to-back blocks have no gap.
              if (i_valid) begin
                vec_q <= i_mx_vec;
                exp_q <= i_mx_exp;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Exact decode of one element: the magnitude has at most 8 significant
  // bits, so it always fits in the 1.7 BF16 significand without rounding.
  function automatic logic [15:0] decode(input logic [bit_width-1:0] e,
                                         input logic [7:0]           x);
    logic                 s;
    logic [bit_width-1:0] m;
    logic [7:0]           m8;
    logic [7:0]           sh;
    int                   p;
    int                   ee;
    s  = e[bit_width-1];
    // The most negative code negates to itself, which read as unsigned is
    // exactly its magnitude 2^(bit_width-1).
    m  = s ? -e : e;
    m8 = 8'(m);
    p  = 0;
    for (int i = 0; i < bit_width; i++) begin
      if (m[i]) p = i;
    end
    // Move the leading one up to bit 7; the bits below it are the fraction.
    sh = m8 << (7 - p);
    ee = int'(x) + p - (bit_width - 2);
    if (x == 8'hFF)      decode = 16'h7FC0;
    else if (m == '0)    decode = 16'h0000;
    else if (ee >= 255)  decode = {s, 8'hFF, 7'h00};
    else if (ee <= 0)    decode = {s, 15'h0000};
    else                 decode = {s, ee[7:0], sh[6:0]};
  endfunction

  always_comb begin
    o_bf16_vec = '0;
    for (int j = 0; j < lanes; j++) begin
      o_bf16_vec[j] = decode(vec_q[beat_q][j], exp_q);
    end
  end

endmodule

// File: tb/tb_conv_mxi8tobf16.sv
module tb_conv_mxi8tobf16;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [31:0][7:0] i_mx_vec;
  logic [7:0]       i_mx_exp;
  logic             o_valid;
  logic             i_ready;
  logic [7:0][15:0] o_bf16_vec;
  logic [1:0]       o_beat;
  logic             o_last;

  int checks = 0;
  int errors = 0;

  // Block A: beat b holds 2^b in every lane; block B holds -(2^b). exp=127.
  logic [15:0] exp_a [4] = '{16'h3C80, 16'h3D00, 16'h3D80, 16'h3E00};
  logic [15:0] exp_b [4] = '{16'hBC80, 16'hBD00, 16'hBD80, 16'hBE00};

  conv_mxi8tobf16 #(.bit_width(8), .k(32), .lanes(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_mx_vec   (i_mx_vec),
    .i_mx_exp   (i_mx_exp),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_bf16_vec (o_bf16_vec),
    .o_beat     (o_beat),
    .o_last     (o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic load_a();
    for (int i = 0; i < 32; i++) i_mx_vec[i] = 8'(8'd1 << (i / 8));
    i_mx_exp = 8'd127;
  endtask

  task automatic load_b();
    for (int i = 0; i < 32; i++) i_mx_vec[i] = 8'(-(8'd1 << (i / 8)));
    i_mx_exp = 8'd127;
  endtask

  // Presents the current i_mx_vec/i_mx_exp for one cycle; returns just after
  // the negedge at which beat 0 is visible, with i_valid low again.
  task automatic send_block();
    @(negedge i_clk);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_mx_vec = '1;
    i_mx_exp = 8'h55;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_mx_vec = '0; i_mx_exp = '0;
    #12;
    checks++;
    if (o_valid !== 1'b0 || o_beat !== 2'd0 || o_ready !== 1'b1 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b beat=%0d ready=%b last=%b required 0 0 1 0",
               o_valid, o_beat, o_ready, o_last);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_l [8] = '{16'h3F80, 16'hBF80, 16'h3C80, 16'hC000,
                               16'h3FFE, 16'h0000, 16'hBFFE, 16'h0000};
    i_ready = 1'b0;
    i_mx_vec = '0;
    i_mx_vec[0] = 8'h40; i_mx_vec[1] = 8'hC0; i_mx_vec[2] = 8'h01;
    i_mx_vec[3] = 8'h80; i_mx_vec[4] = 8'h7F; i_mx_vec[5] = 8'h00;
    i_mx_vec[6] = 8'h81; i_mx_vec[7] = 8'h00;
    i_mx_vec[8] = 8'h40;
    i_mx_exp = 8'd127;
    send_block();
    checks++;
    if (o_valid !== 1'b1 || o_beat !== 2'd0 || o_last !== 1'b0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_beat0_ctrl: valid=%b beat=%0d last=%b ready=%b required 1 0 0 0",
               o_valid, o_beat, o_last, o_ready);
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (o_bf16_vec[j] !== exp_l[j]) begin
        errors++;
        $display("FAIL basic_lane%0d: got %h required %h", j, o_bf16_vec[j], exp_l[j]);
      end
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_beat !== 2'd1 || o_bf16_vec[0] !== 16'h3F80 || o_bf16_vec[1] !== 16'h0000) begin
      errors++;
      $display("FAIL basic_beat1: beat=%0d lane0=%h lane1=%h required 1 3f80 0000",
               o_beat, o_bf16_vec[0], o_bf16_vec[1]);
    end
    for (int b = 2; b < 4; b++) begin
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_beat !== 2'(b) || o_last !== (b == 3)) begin
        errors++;
        $display("FAIL basic_drain%0d: valid=%b beat=%0d last=%b", b, o_valid, o_beat, o_last);
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_nan();
    for (int i = 0; i < 32; i++) i_mx_vec[i] = 8'(i * 37 + 3);
    i_mx_vec[5] = 8'h00;
    i_mx_exp = 8'hFF;
    i_ready = 1'b1;
    send_block();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_beat !== 2'(b) || o_last !== (b == 3)) begin
        errors++;
        $display("FAIL nan_ctrl%0d: valid=%b beat=%0d last=%b", b, o_valid, o_beat, o_last);
      end
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (o_bf16_vec[j] !== 16'h7FC0) begin
          errors++;
          $display("FAIL nan_b%0d_l%0d: got %h required 7fc0", b, j, o_bf16_vec[j]);
        end
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL nan_idle: valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_extremes();
    // Overflow edge: E=255 saturates to Inf, E=254 is the largest finite.
    i_ready = 1'b0;
    i_mx_vec = '0;
    i_mx_vec[0] = 8'h80; i_mx_vec[1] = 8'h7F;
    i_mx_exp = 8'd254;
    send_block();
    checks++;
    if (o_bf16_vec[0] !== 16'hFF80 || o_bf16_vec[1] !== 16'h7F7E) begin
      errors++;
      $display("FAIL ovf: lane0=%h lane1=%h required ff80 7f7e", o_bf16_vec[0], o_bf16_vec[1]);
    end
    i_ready = 1'b1;
    repeat (4) @(negedge i_clk);
    // Underflow edge: E=0 flushes (keeping sign), E=1 is the smallest normal.
    i_ready = 1'b0;
    i_mx_vec = '0;
    i_mx_vec[0] = 8'hFE; i_mx_vec[1] = 8'hFC; i_mx_vec[2] = 8'h02;
    i_mx_exp = 8'd5;
    send_block();
    checks++;
    if (o_bf16_vec[0] !== 16'h8000 || o_bf16_vec[1] !== 16'h8080 || o_bf16_vec[2] !== 16'h0000) begin
      errors++;
      $display("FAIL flush5: lanes=%h %h %h required 8000 8080 0000",
               o_bf16_vec[0], o_bf16_vec[1], o_bf16_vec[2]);
    end
    i_ready = 1'b1;
    repeat (4) @(negedge i_clk);
    i_ready = 1'b0;
    i_mx_vec = '0;
    i_mx_vec[0] = 8'h40;
    i_mx_exp = 8'd0;
    send_block();
    checks++;
    if (o_bf16_vec[0] !== 16'h0000) begin
      errors++;
      $display("FAIL flush0: got %h required 0000", o_bf16_vec[0]);
    end
    i_ready = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    load_a();
    @(negedge i_clk);
    i_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (c == 0) load_b();
      if (c == 4) i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_beat !== 2'(c % 4) || o_ready !== ((c % 4) == 3) ||
          o_bf16_vec[0] !== (c < 4 ? exp_a[c % 4] : exp_b[c % 4]) ||
          o_bf16_vec[7] !== (c < 4 ? exp_a[c % 4] : exp_b[c % 4])) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%b beat=%0d ready=%b lane0=%h lane7=%h required 1 %0d %b %h",
                 c, o_valid, o_beat, o_ready, o_bf16_vec[0], o_bf16_vec[7],
                 c % 4, (c % 4) == 3, (c < 4 ? exp_a[c % 4] : exp_b[c % 4]));
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b1;
    load_a();
    send_block();
    checks++;
    if (o_beat !== 2'd0 || o_bf16_vec[3] !== exp_a[0]) begin
      errors++;
      $display("FAIL bp_beat0: beat=%0d lane3=%h required 0 %h", o_beat, o_bf16_vec[3], exp_a[0]);
    end
    @(negedge i_clk);
    i_ready = 1'b0;
    for (int h = 0; h < 4; h++) begin
      if (h > 0) @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_beat !== 2'd1 || o_ready !== 1'b0 || o_last !== 1'b0 ||
          o_bf16_vec[3] !== exp_a[1]) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b beat=%0d ready=%b last=%b lane3=%h required 1 1 0 0 %h",
                 h, o_valid, o_beat, o_ready, o_last, o_bf16_vec[3], exp_a[1]);
      end
    end
    i_ready = 1'b1;
    for (int b = 2; b < 4; b++) begin
      @(negedge i_clk);
      checks++;
      if (o_beat !== 2'(b) || o_bf16_vec[3] !== exp_a[b] || o_last !== (b == 3)) begin
        errors++;
        $display("FAIL bp_resume%0d: beat=%0d lane3=%h last=%b required %0d %h",
                 b, o_beat, o_bf16_vec[3], o_last, b, exp_a[b]);
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    load_a();
    send_block();
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_beat !== 2'd2 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: beat=%0d valid=%b required 2 1", o_beat, o_valid);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_beat !== 2'd0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b beat=%0d ready=%b required 0 0 1",
               o_valid, o_beat, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
    load_b();
    send_block();
    checks++;
    if (o_beat !== 2'd0 || o_valid !== 1'b1 || o_bf16_vec[0] !== exp_b[0]) begin
      errors++;
      $display("FAIL rstmid_next: beat=%0d valid=%b lane0=%h required 0 1 %h",
               o_beat, o_valid, o_bf16_vec[0], exp_b[0]);
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_end: valid=%b required 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
